// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: register-file geometry and the
// position of the destination-register field inside an instruction word.
package riscv_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int RD_LSB     = 7;
   localparam int RD_MSB     = 11;

   // Extract the destination register index from a 32-bit instruction.
   function automatic logic [REG_ADDR_W-1:0] get_rd(input logic [31:0] instr);
      return instr[RD_MSB:RD_LSB];
   endfunction

endpackage

// File: rtl/wb_read_mux.sv
// One register-file read port: selects between the stored register value
// and the write-back bypass, and forces zero for x0 and while in reset.
// The bypass hit is computed by the parent; with WB_BYPASS_EN undefined the
// parent ties it low, so this mux then only ever shows the stored value.
module wb_read_mux
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  i_reset,
   input  logic [REG_ADDR_W-1:0] i_rs_addr,
   input  logic [XLEN-1:0]       i_stored,
   input  logic                  i_byp_hit,
   input  logic [XLEN-1:0]       i_byp_data,
   output logic [XLEN-1:0]       o_rs_data
);

   // Priority select: reset, then x0, then bypass, then stored value.
   always_comb begin
      o_rs_data = {XLEN{1'b0}};
      if (i_reset) begin
         o_rs_data = {XLEN{1'b0}};
      end else if (i_rs_addr == {REG_ADDR_W{1'b0}}) begin
         o_rs_data = {XLEN{1'b0}};
      end else if (i_byp_hit) begin
         o_rs_data = i_byp_data;
      end else begin
         o_rs_data = i_stored;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// 32 x XLEN integer register file written from the MEM/WB stage, with two
// combinational read ports for decode and a committed-write counter.
// Optional macro WB_BYPASS_EN: when defined, a write in flight is visible
// on a matching read port in the same cycle (write-through bypass).
module wb_regfile
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           wb_instr,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data,
   output logic [31:0]           wr_count
);

   logic [XLEN-1:0]       r_regs [NUM_REGS];
   logic [31:0]           r_wr_count;
   logic [REG_ADDR_W-1:0] w_rd;
   logic                  w_wr_en;
   logic                  w_rs1_hit;
   logic                  w_rs2_hit;
   logic                  w_unused_instr;

   // Only rd is taken from the instruction; the other fields are don't-care.
   assign w_rd           = get_rd(wb_instr);
   assign w_unused_instr = ^{wb_instr[31:RD_MSB+1], wb_instr[RD_LSB-1:0]};

   // A write commits only for a nonzero rd outside reset; x0 is never written.
   assign w_wr_en = wb_we & ~reset & (w_rd != {REG_ADDR_W{1'b0}});

`ifdef WB_BYPASS_EN
   assign w_rs1_hit = w_wr_en & (w_rd == rs1_addr);
   assign w_rs2_hit = w_wr_en & (w_rd == rs2_addr);
`else
   assign w_rs1_hit = 1'b0;
   assign w_rs2_hit = 1'b0;
`endif

   // Register storage: cleared asynchronously, written on the rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= {XLEN{1'b0}};
         end
      end else if (w_wr_en) begin
         r_regs[w_rd] <= wb_data;
      end
   end

   // Committed-write counter; wraps naturally at 32 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_count <= 32'd0;
      end else if (w_wr_en) begin
         r_wr_count <= r_wr_count + 32'd1;
      end
   end

   assign wr_count = r_wr_count;

   wb_read_mux #(.XLEN(XLEN)) u_rd_mux_rs1 (
      .i_reset    (reset),
      .i_rs_addr  (rs1_addr),
      .i_stored   (r_regs[rs1_addr]),
      .i_byp_hit  (w_rs1_hit),
      .i_byp_data (wb_data),
      .o_rs_data  (rs1_data)
   );

   wb_read_mux #(.XLEN(XLEN)) u_rd_mux_rs2 (
      .i_reset    (reset),
      .i_rs_addr  (rs2_addr),
      .i_stored   (r_regs[rs2_addr]),
      .i_byp_hit  (w_rs2_hit),
      .i_byp_data (wb_data),
      .o_rs_data  (rs2_data)
   );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (XLEN=32). Builds with or
// without WB_BYPASS_EN; the same-cycle read expectation follows the macro.
module tb_wb_regfile;

   logic        clk;
   logic        reset;
   logic [31:0] wb_instr;
   logic [31:0] wb_data;
   logic        wb_we;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wr_count;

   int checks   = 0;
   int failures = 0;

   wb_regfile #(.XLEN(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_instr (wb_instr),
      .wb_data  (wb_data),
      .wb_we    (wb_we),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .wr_count (wr_count)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
         $error("%s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Instruction word with rd in [11:7] and arbitrary filler elsewhere.
   function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [19:0] hi,
                                            input logic [6:0] op);
      return {hi, rd, op};
   endfunction

   // Present a write at the falling edge; it commits on the following rising edge.
   task automatic do_write(input logic [4:0] rd, input logic [31:0] data);
      @(negedge clk);
      wb_we    = 1'b1;
      wb_instr = mk_instr(rd, 20'h00000, 7'h33);
      wb_data  = data;
      @(negedge clk);
      wb_we    = 1'b0;
      wb_instr = 32'h0000_0013;
      wb_data  = 32'h0000_0000;
   endtask

   logic [31:0] exp_byp;

   initial begin
      reset    = 1'b0;
      wb_we    = 1'b0;
      wb_instr = 32'h0000_0013;
      wb_data  = 32'h0000_0000;
      rs1_addr = 5'd5;
      rs2_addr = 5'd0;
      #2 reset = 1'b1;

      // Reset state
      @(negedge clk);
      #1;
      chk("reset_count", wr_count, 32'h0000_0000);
      chk("reset_rs1", rs1_data, 32'h0000_0000);
      chk("reset_rs2_x0", rs2_data, 32'h0000_0000);

      // First write right after reset release
      @(negedge clk);
      reset    = 1'b0;
      wb_we    = 1'b1;
      wb_instr = mk_instr(5'd5, 20'hABCDE, 7'h03);
      wb_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      wb_we    = 1'b0;
      #1;
      chk("first_write_x5", rs1_data, 32'hDEAD_BEEF);
      chk("first_write_count", wr_count, 32'h0000_0001);

      // Reset asserted while a write to x5 is pending across the edge
      wb_we    = 1'b1;
      wb_instr = mk_instr(5'd5, 20'h00000, 7'h33);
      wb_data  = 32'h1111_1111;
      reset    = 1'b1;
      #1;
      chk("async_reset_count", wr_count, 32'h0000_0000);
      chk("reset_rs1_forced", rs1_data, 32'h0000_0000);
      @(negedge clk);
      reset = 1'b0;
      wb_we = 1'b0;
      #1;
      chk("reset_mid_write_x5", rs1_data, 32'h0000_0000);
      chk("reset_mid_write_count", wr_count, 32'h0000_0000);

      // x0 protection
      @(negedge clk);
      rs1_addr = 5'd0;
      wb_we    = 1'b1;
      wb_instr = mk_instr(5'd0, 20'hFFFFF, 7'h33);
      wb_data  = 32'h1234_5678;
      #1;
      chk("x0_same_cycle", rs1_data, 32'h0000_0000);
      @(negedge clk);
      wb_we = 1'b0;
      #1;
      chk("x0_after_edge", rs1_data, 32'h0000_0000);
      chk("x0_count", wr_count, 32'h0000_0000);

      // Bypass path: write x7 and read it in the same cycle
`ifdef WB_BYPASS_EN
      exp_byp = 32'hA5A5_A5A5;
`else
      exp_byp = 32'h0000_0000;
`endif
      rs1_addr = 5'd7;
      rs2_addr = 5'd6;
      wb_we    = 1'b1;
      wb_instr = mk_instr(5'd7, 20'h12345, 7'h13);
      wb_data  = 32'hA5A5_A5A5;
      #1;
      chk("bypass_same_cycle", rs1_data, exp_byp);
      chk("bypass_other_port", rs2_data, 32'h0000_0000);
      @(negedge clk);
      wb_we = 1'b0;
      #1;
      chk("bypass_next_cycle", rs1_data, 32'hA5A5_A5A5);
      chk("bypass_count", wr_count, 32'h0000_0001);

      // Back-to-back writes to x3
      @(negedge clk);
      rs1_addr = 5'd3;
      wb_we    = 1'b1;
      wb_instr = mk_instr(5'd3, 20'h00000, 7'h33);
      wb_data  = 32'h0000_0001;
      @(negedge clk);
      wb_data  = 32'h0000_0002;
      @(negedge clk);
      wb_we    = 1'b0;
      #1;
      chk("same_reg_x3", rs1_data, 32'h0000_0002);
      chk("same_reg_count", wr_count, 32'h0000_0003);

      // Both ports on the same address
      do_write(5'd9, 32'h0000_0042);
      rs1_addr = 5'd9;
      rs2_addr = 5'd9;
      #1;
      chk("dual_port_rs1", rs1_data, 32'h0000_0042);
      chk("dual_port_rs2", rs2_data, 32'h0000_0042);
      chk("dual_port_count", wr_count, 32'h0000_0004);

      // Non-rd instruction fields ignored; wb_we=0 blocks a write
      @(negedge clk);
      wb_we    = 1'b1;
      wb_instr = 32'hFFFF_F57F;
      wb_data  = 32'hCAFE_0010;
      @(negedge clk);
      wb_we    = 1'b0;
      wb_instr = mk_instr(5'd11, 20'hFFFFF, 7'h7F);
      wb_data  = 32'hBAD0_0011;
      @(negedge clk);
      rs1_addr = 5'd10;
      rs2_addr = 5'd11;
      #1;
      chk("instr_fields_x10", rs1_data, 32'hCAFE_0010);
      chk("we_low_x11", rs2_data, 32'h0000_0000);
      chk("we_low_count", wr_count, 32'h0000_0005);
      chk("x3_retained", dut.r_regs[3], 32'h0000_0002);

      // Counter wrap
      @(negedge clk);
      force dut.r_wr_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_wr_count;
      #1;
      chk("wrap_preload", wr_count, 32'hFFFF_FFFF);
      do_write(5'd12, 32'h0000_7777);
      rs1_addr = 5'd12;
      #1;
      chk("wrap_count", wr_count, 32'h0000_0000);
      chk("wrap_write_x12", rs1_data, 32'h0000_7777);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
